// File: rtl/backprop_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : backprop_controller_pkg
//  Description : Shared constants and FSM state encoding for the backprop
//                sequencing controller.
//  Revision    : 1.0
// ============================================================================
package backprop_controller_pkg;

    localparam int C_AWIDTH        = 10;
    localparam int C_HIDDEN_NEURON = 16;
    localparam int C_NUM_SRC_W     = 5;
    localparam int C_IDX_W         = 4;
    localparam int C_STATE_W       = 3;

    typedef logic [C_STATE_W-1:0] state_t;

    localparam state_t C_ST_IDLE  = 3'd0;
    localparam state_t C_ST_READ  = 3'd1;
    localparam state_t C_ST_WAIT  = 3'd2;
    localparam state_t C_ST_CALC  = 3'd3;
    localparam state_t C_ST_WRITE = 3'd4;
    localparam state_t C_ST_DONE  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/backprop_controller.sv
`default_nettype none
// ============================================================================
//  Module      : backprop_controller
//  Description : Sequences one backprop pass per source neuron
//                (READ/WAIT/CALC/WRITE), all outputs registered.
//  Revision    : 1.0
// ============================================================================
module backprop_controller
    import backprop_controller_pkg::*;
#(
    parameter int AWIDTH       = C_AWIDTH,
    parameter int HiddenNeuron = C_HIDDEN_NEURON
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [C_NUM_SRC_W-1:0]  num_src,
    input  logic [AWIDTH-1:0]       w_base,
    input  logic [AWIDTH-1:0]       a_base,
    output logic                    busy,
    output logic                    done,
    output logic                    bram_en,
    output logic                    bram_we,
    output logic [AWIDTH-1:0]       bram_addr,
    output logic [AWIDTH-1:0]       act_addr,
    output logic                    enable_delta,
    output logic                    enable_write_w,
    output logic [HiddenNeuron-1:0] enable_calc_delta,
    output logic [C_IDX_W-1:0]      idx
);

    state_t                   r_state,    w_state_nxt;
    logic [C_NUM_SRC_W-1:0]   r_num_src,  w_num_src_nxt;
    logic [AWIDTH-1:0]        r_w_base,   w_w_base_nxt;
    logic [AWIDTH-1:0]        r_a_base,   w_a_base_nxt;
    logic [C_IDX_W-1:0]       r_idx,      w_idx_nxt;

    logic                     r_busy,     w_busy_nxt;
    logic                     r_done,     w_done_nxt;
    logic                     r_bram_en,  w_bram_en_nxt;
    logic                     r_bram_we,  w_bram_we_nxt;
    logic                     r_en_delta, w_en_delta_nxt;
    logic                     r_en_wr_w,  w_en_wr_w_nxt;
    logic [AWIDTH-1:0]        r_bram_addr, w_bram_addr_nxt;
    logic [AWIDTH-1:0]        r_act_addr,  w_act_addr_nxt;
    logic [HiddenNeuron-1:0]  r_ecd,       w_ecd_nxt;

    logic [C_NUM_SRC_W-1:0]   w_num_src_clamped;
    logic                     w_last_idx;
    logic                     w_in_pass;

    assign w_num_src_clamped = (num_src > C_NUM_SRC_W'(HiddenNeuron))
                             ? C_NUM_SRC_W'(HiddenNeuron) : num_src;
    assign w_last_idx = ({1'b0, r_idx} == (r_num_src - 5'd1));

    // State, latched configuration and the registered Moore outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= C_ST_IDLE;
            r_num_src   <= '0;
            r_w_base    <= '0;
            r_a_base    <= '0;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bram_en   <= 1'b0;
            r_bram_we   <= 1'b0;
            r_en_delta  <= 1'b0;
            r_en_wr_w   <= 1'b0;
            r_bram_addr <= '0;
            r_act_addr  <= '0;
            r_ecd       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_num_src   <= w_num_src_nxt;
            r_w_base    <= w_w_base_nxt;
            r_a_base    <= w_a_base_nxt;
            r_idx       <= w_idx_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_bram_en   <= w_bram_en_nxt;
            r_bram_we   <= w_bram_we_nxt;
            r_en_delta  <= w_en_delta_nxt;
            r_en_wr_w   <= w_en_wr_w_nxt;
            r_bram_addr <= w_bram_addr_nxt;
            r_act_addr  <= w_act_addr_nxt;
            r_ecd       <= w_ecd_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_num_src_nxt = r_num_src;
        w_w_base_nxt  = r_w_base;
        w_a_base_nxt  = r_a_base;
        w_idx_nxt     = r_idx;
        case (r_state)
            C_ST_IDLE: begin
                if (start) begin
                    w_num_src_nxt = w_num_src_clamped;
                    w_w_base_nxt  = w_base;
                    w_a_base_nxt  = a_base;
                    w_idx_nxt     = '0;
                    w_state_nxt   = (w_num_src_clamped != '0) ? C_ST_READ : C_ST_DONE;
                end
            end
            C_ST_READ:  w_state_nxt = C_ST_WAIT;
            C_ST_WAIT:  w_state_nxt = C_ST_CALC;
            C_ST_CALC:  w_state_nxt = C_ST_WRITE;
            C_ST_WRITE: begin
                if (w_last_idx) begin
                    w_state_nxt = C_ST_DONE;
                end else begin
                    w_idx_nxt   = r_idx + 4'd1;
                    w_state_nxt = C_ST_READ;
                end
            end
            C_ST_DONE:  w_state_nxt = C_ST_IDLE;
            default:    w_state_nxt = C_ST_IDLE;
        endcase
    end

    // Outputs decoded from the next state so they land registered with it
    always_comb begin
        w_in_pass       = (w_state_nxt == C_ST_READ) || (w_state_nxt == C_ST_WAIT) ||
                          (w_state_nxt == C_ST_CALC) || (w_state_nxt == C_ST_WRITE);
        w_busy_nxt      = (w_state_nxt != C_ST_IDLE);
        w_done_nxt      = (w_state_nxt == C_ST_DONE);
        w_bram_en_nxt   = (w_state_nxt == C_ST_READ);
        w_bram_we_nxt   = (w_state_nxt == C_ST_WRITE);
        w_en_delta_nxt  = (w_state_nxt == C_ST_CALC);
        w_en_wr_w_nxt   = (w_state_nxt == C_ST_CALC);
        w_bram_addr_nxt = '0;
        w_act_addr_nxt  = '0;
        w_ecd_nxt       = '0;
        if (w_in_pass) begin
            w_bram_addr_nxt = w_w_base_nxt + AWIDTH'(w_idx_nxt);
            w_act_addr_nxt  = w_a_base_nxt + AWIDTH'(w_idx_nxt);
        end
        if (w_state_nxt == C_ST_WRITE) begin
            w_ecd_nxt = HiddenNeuron'(1) << w_idx_nxt;
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign bram_en           = r_bram_en;
    assign bram_we           = r_bram_we;
    assign bram_addr         = r_bram_addr;
    assign act_addr          = r_act_addr;
    assign enable_delta      = r_en_delta;
    assign enable_write_w    = r_en_wr_w;
    assign enable_calc_delta = r_ecd;
    assign idx               = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_backprop_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_backprop_controller
//  Description : Directed and randomized passes checked cycle by cycle
//                against a phase/index arithmetic reference.
//  Revision    : 1.0
// ============================================================================
module tb_backprop_controller;

    localparam int AW = 10;
    localparam int HN = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    num_src;
    logic [AW-1:0] w_base;
    logic [AW-1:0] a_base;
    logic          busy, done, bram_en, bram_we;
    logic [AW-1:0] bram_addr, act_addr;
    logic          enable_delta, enable_write_w;
    logic [HN-1:0] enable_calc_delta;
    logic [3:0]    idx;

    int n_cmp = 0;
    int n_err = 0;

    backprop_controller #(.AWIDTH(AW), .HiddenNeuron(HN)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .num_src           (num_src),
        .w_base            (w_base),
        .a_base            (a_base),
        .busy              (busy),
        .done              (done),
        .bram_en           (bram_en),
        .bram_we           (bram_we),
        .bram_addr         (bram_addr),
        .act_addr          (act_addr),
        .enable_delta      (enable_delta),
        .enable_write_w    (enable_write_w),
        .enable_calc_delta (enable_calc_delta),
        .idx               (idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, " busy"}, 32'(busy), 0);
        chk({pfx, " done"}, 32'(done), 0);
        chk({pfx, " bram_en"}, 32'(bram_en), 0);
        chk({pfx, " bram_we"}, 32'(bram_we), 0);
        chk({pfx, " en_delta"}, 32'(enable_delta), 0);
        chk({pfx, " en_write_w"}, 32'(enable_write_w), 0);
        chk({pfx, " ecd"}, 32'(enable_calc_delta), 0);
        chk({pfx, " idx"}, 32'(idx), 0);
        chk({pfx, " bram_addr"}, 32'(bram_addr), 0);
        chk({pfx, " act_addr"}, 32'(act_addr), 0);
    endtask

    // Reference: cycle c after the accepted start; each source neuron takes
    // four cycles (read, wait, calc, write), done follows the last one.
    task automatic check_cycle(input int c, input int n, input int wb, input int ab,
                               input string pfx);
        int  total;
        int  i, p;
        bit  in_pass;
        logic [31:0] e_ecd;
        string t;
        total   = (n == 0) ? 1 : 4 * n + 1;
        in_pass = (n > 0) && (c <= 4 * n);
        i = in_pass ? (c - 1) / 4 : 0;
        p = in_pass ? (c - 1) % 4 : -1;
        e_ecd = (p == 3) ? (32'd1 << i) : 32'd0;
        t = $sformatf("%s c%0d", pfx, c);
        chk({t, " busy"}, 32'(busy), (c <= total) ? 1 : 0);
        chk({t, " done"}, 32'(done), (c == total) ? 1 : 0);
        chk({t, " bram_en"}, 32'(bram_en), (p == 0) ? 1 : 0);
        chk({t, " bram_we"}, 32'(bram_we), (p == 3) ? 1 : 0);
        chk({t, " en_delta"}, 32'(enable_delta), (p == 2) ? 1 : 0);
        chk({t, " en_write_w"}, 32'(enable_write_w), (p == 2) ? 1 : 0);
        chk({t, " ecd"}, 32'(enable_calc_delta), e_ecd);
        if (in_pass) begin
            chk({t, " idx"}, 32'(idx), 32'(i));
            chk({t, " bram_addr"}, 32'(bram_addr), 32'((wb + i) % (1 << AW)));
            chk({t, " act_addr"}, 32'(act_addr), 32'((ab + i) % (1 << AW)));
        end
    endtask

    // One full pass; optionally keeps start high with junk config throughout
    task automatic run_pass(input int n_in, input int wb, input int ab, input bit hammer,
                            input string pfx);
        int n, total;
        n     = (n_in > HN) ? HN : n_in;
        total = (n == 0) ? 1 : 4 * n + 1;
        num_src = 5'(n_in);
        w_base  = AW'(wb);
        a_base  = AW'(ab);
        start   = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= total + 2; c++) begin
            start = hammer && (c <= total);
            if (hammer) begin
                num_src = 5'($urandom);
                w_base  = AW'($urandom);
                a_base  = AW'($urandom);
            end
            check_cycle(c, n, wb, ab, pfx);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        num_src = '0;
        w_base  = '0;
        a_base  = '0;
        @(posedge clk); #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_pass(16, 'h100, 'h040, 1'b0, "full16");
        run_pass(0, 'h155, 'h2AA, 1'b0, "zero");
        run_pass(3, 'h3FE, 'h3FF, 1'b0, "wrap");
        run_pass(25, 'h010, 'h020, 1'b0, "clamp");

        // Reset asserted in the CALC cycle of idx 5
        num_src = 5'd8;
        w_base  = AW'('h200);
        a_base  = AW'('h010);
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 23; c++) begin
            check_cycle(c, 8, 'h200, 'h010, "prerst");
            @(posedge clk); #1;
        end
        chk("prerst c23 en_delta", 32'(enable_delta), 1);
        chk("prerst c23 idx", 32'(idx), 5);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        @(posedge clk); #1;
        chk_zero("midrst_hold");
        rst = 1'b0;

        run_pass(5, 'h0F0, 'h0F8, 1'b0, "postrst");
        run_pass(2, 'h0AB, 'h0CD, 1'b1, "hammer");

        for (int k = 0; k < 6; k++) begin
            run_pass(int'($urandom_range(0, 20)), int'($urandom_range(0, 1023)),
                     int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                     $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
